// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and BCD constants for the stopwatch controller
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         NUM_DIGITS = 4;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, level debouncer and one-cycle press pulse
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
      // Any sample agreeing with the accepted level restarts the stability run.
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/clear sequencer, BCD up/down counter and display scan
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int SCAN_DIV   = 100000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        up_down,
  output logic [15:0] digits,
  output logic [3:0]  an,
  output logic [3:0]  digit_sel,
  output logic        rc,
  output logic        running
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV + 1);

  logic          w_start_pulse;
  logic          w_clear_pulse;
  logic          w_tick;
  logic          w_carry;
  logic [15:0]   w_next_digits;

  state_t        r_state;
  logic          r_running;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_digits;
  logic          r_rc;
  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_an;
  logic [3:0]    r_digit_sel;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_start),
    .o_pulse (w_start_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_clear),
    .o_pulse (w_clear_pulse)
  );

  assign w_tick = (r_state == ST_RUN) && (r_presc == PW'(TICK_DIV - 1));

  // Ripple carry/borrow through the digits; a carry out of digit3 is the wrap.
  always_comb begin
    w_next_digits = r_digits;
    w_carry       = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_carry) begin
        if (up_down) begin
          if (r_digits[4*i +: 4] >= BCD_MAX) begin
            w_next_digits[4*i +: 4] = 4'd0;
          end else begin
            w_next_digits[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
            w_carry = 1'b0;
          end
        end else begin
          if (r_digits[4*i +: 4] == 4'd0) begin
            w_next_digits[4*i +: 4] = BCD_MAX;
          end else begin
            w_next_digits[4*i +: 4] = r_digits[4*i +: 4] - 4'd1;
            w_carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_presc   <= '0;
      r_digits  <= '0;
      r_rc      <= 1'b0;
    end else if (w_clear_pulse) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_presc   <= '0;
      r_digits  <= '0;
      r_rc      <= 1'b0;
    end else begin
      r_rc <= w_tick & w_carry;
      if (w_tick) begin
        r_digits <= w_next_digits;
      end
      // Prescaler only advances in RUN, so PAUSE keeps the tick phase.
      if (r_state == ST_RUN) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end
      if (w_start_pulse) begin
        case (r_state)
          ST_IDLE, ST_PAUSE: begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
          ST_RUN: begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end
          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_idx       <= 2'd0;
      r_an        <= 4'b1110;
      r_digit_sel <= 4'd0;
    end else begin
      r_an        <= ~(4'b0001 << r_idx);
      r_digit_sel <= r_digits[{r_idx, 2'b00} +: 4];
      if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_idx      <= r_idx + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + SW'(1);
      end
    end
  end

  assign digits    = r_digits;
  assign an        = r_an;
  assign digit_sel = r_digit_sel;
  assign rc        = r_rc;
  assign running   = r_running;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed and randomized checks of stopwatch_ctrl against a decimal model
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int DEB      = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_start;
  logic        btn_clear;
  logic        up_down;
  logic [15:0] digits;
  logic [3:0]  an;
  logic [3:0]  digit_sel;
  logic        rc;
  logic        running;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: count is a plain integer 0..9999, mode 0=idle 1=run 2=pause.
  bit          m_d1 [2];
  bit          m_d2 [2];
  bit          m_lvl [2];
  bit          m_rise [2];
  bit          m_pulse [2];
  int          m_run [2];
  int          m_mode;
  int          m_count;
  bit          m_rc;
  int          m_presc;
  int          m_scan_cnt;
  int          m_idx;
  logic [3:0]  m_an;
  logic [3:0]  m_sel;

  stopwatch_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .SCAN_DIV   (SCAN_DIV),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .up_down   (up_down),
    .digits    (digits),
    .an        (an),
    .digit_sel (digit_sel),
    .rc        (rc),
    .running   (running)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_step();
    bit raw [2];
    bit clr;
    bit sta;
    bit tick;
    bit din;
    logic [15:0] bcd;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0; m_rise[b] = 0; m_pulse[b] = 0; m_run[b] = 0;
      end
      m_mode = 0; m_count = 0; m_rc = 0; m_presc = 0;
      m_scan_cnt = 0; m_idx = 0; m_an = 4'b1110; m_sel = 4'd0;
      return;
    end
    raw[0] = btn_start;
    raw[1] = btn_clear;
    sta = m_pulse[0];
    clr = m_pulse[1];
    for (int b = 0; b < 2; b++) begin
      m_pulse[b] = m_rise[b];
      m_rise[b]  = 0;
      din = m_d2[b];
      if (din != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_lvl[b]  = din;
          m_run[b]  = 0;
          m_rise[b] = din;
        end
      end else begin
        m_run[b] = 0;
      end
      m_d2[b] = m_d1[b];
      m_d1[b] = raw[b];
    end
    bcd   = to_bcd(m_count);
    m_an  = ~(4'b0001 << m_idx);
    m_sel = bcd[4*m_idx +: 4];
    if (m_scan_cnt == SCAN_DIV - 1) begin
      m_scan_cnt = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_scan_cnt++;
    end
    tick = (m_mode == 1) && (m_presc == TICK_DIV - 1);
    if (clr) begin
      m_mode = 0; m_count = 0; m_presc = 0; m_rc = 0;
    end else begin
      m_rc = 0;
      if (tick) begin
        if (up_down) begin
          m_count = (m_count + 1) % 10000;
          m_rc = (m_count == 0);
        end else begin
          m_count = (m_count + 9999) % 10000;
          m_rc = (m_count == 9999);
        end
      end
      if (m_mode == 1) m_presc = (m_presc + 1) % TICK_DIV;
      if (sta) m_mode = (m_mode == 1) ? 2 : 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic press(input logic s, input logic c);
    @(negedge clk);
    btn_start = s;
    btn_clear = c;
    repeat (DEB + 4) @(negedge clk);
    btn_start = 1'b0;
    btn_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_start = 1'b0; btn_clear = 1'b0; up_down = 1'b1;
    repeat (2) @(negedge clk);
    n_checks += 5;
    if (digits !== 16'h0000) begin n_fail++; $display("FAIL reset_digits: got %h expected 0000", digits); end
    if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
    if (rc !== 1'b0) begin n_fail++; $display("FAIL reset_rc: got %b expected 0", rc); end
    if (an !== 4'b1110) begin n_fail++; $display("FAIL reset_an: got %b expected 1110", an); end
    if (digit_sel !== 4'd0) begin n_fail++; $display("FAIL reset_sel: got %h expected 0", digit_sel); end
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_checks += 3;
      if (an !== m_an) begin n_fail++; $display("FAIL scan_an: got %b expected %b", an, m_an); end
      if ($countones(~an) != 1) begin n_fail++; $display("FAIL scan_onehot: got %b expected one low", an); end
      if (digit_sel !== 4'd0 || digits !== 16'h0 || running !== 1'b0) begin
        n_fail++; $display("FAIL idle_outputs: got sel=%h digits=%h run=%b expected 0", digit_sel, digits, running);
      end
    end
  endtask

  task automatic test_debounce();
    int lat;
    @(negedge clk);
    btn_start = 1'b1;
    repeat (2) @(negedge clk);
    btn_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (running !== 1'b0) begin n_fail++; $display("FAIL glitch_running: got %b expected 0", running); end
    end
    btn_start = 1'b1;
    lat = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      lat++;
      if (running === 1'b1) break;
    end
    n_checks++;
    if (lat != DEB + 4) begin n_fail++; $display("FAIL start_latency: got %0d expected %0d", lat, DEB + 4); end
    repeat (10 - lat) @(negedge clk);
    btn_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (running !== 1'b1) begin n_fail++; $display("FAIL single_pulse: got running=%b expected 1", running); end
    end
  endtask

  task automatic wait_change(input string name, input int budget, output logic [15:0] val);
    logic [15:0] prev;
    bit seen;
    prev = digits;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (digits !== prev) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL %s_timeout: got no change from %h expected a change", name, prev); end
    val = digits;
  endtask

  task automatic test_count_up();
    logic [15:0] v;
    bit seen;
    up_down = 1'b1;
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL up_start: got %b expected 1", running); end
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (digits === 16'h0009) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL reach_0009: got %h expected 0009", digits); end
    wait_change("carry", 8, v);
    n_checks += 2;
    if (v !== 16'h0010) begin n_fail++; $display("FAIL carry_0010: got %h expected 0010", v); end
    if (v !== to_bcd(m_count)) begin n_fail++; $display("FAIL carry_model: got %h expected %h", v, to_bcd(m_count)); end
  endtask

  task automatic test_count_down();
    logic [15:0] v;
    @(negedge clk);
    up_down = 1'b0;
    wait_change("borrow", 8, v);
    n_checks++;
    if (v !== 16'h0009) begin n_fail++; $display("FAIL borrow_0009: got %h expected 0009", v); end
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    wait_change("down_wrap", 8, v);
    n_checks += 2;
    if (v !== 16'h9999) begin n_fail++; $display("FAIL down_wrap: got %h expected 9999", v); end
    if (rc !== 1'b1) begin n_fail++; $display("FAIL down_rc: got %b expected 1", rc); end
    @(negedge clk);
    n_checks++;
    if (rc !== 1'b0) begin n_fail++; $display("FAIL down_rc_width: got %b expected 0", rc); end
    up_down = 1'b1;
    wait_change("up_wrap", 8, v);
    n_checks += 2;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL up_wrap: got %h expected 0000", v); end
    if (rc !== 1'b1) begin n_fail++; $display("FAIL up_rc: got %b expected 1", rc); end
    @(negedge clk);
    n_checks++;
    if (rc !== 1'b0) begin n_fail++; $display("FAIL up_rc_width: got %b expected 0", rc); end
  endtask

  task automatic test_pause_resume();
    logic [15:0] frozen;
    int gap;
    press(1'b0, 1'b1);
    @(negedge clk);
    btn_start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (running === 1'b1) break;
    end
    btn_start = 1'b0;
    repeat (7) @(negedge clk);
    btn_start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (running === 1'b0) break;
    end
    btn_start = 1'b0;
    frozen = digits;
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL pause_enter: got %b expected 0", running); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (digits !== frozen || rc !== 1'b0) begin
        n_fail++; $display("FAIL pause_frozen: got %h rc=%b expected %h rc=0", digits, rc, frozen);
      end
    end
    btn_start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (running === 1'b1) break;
    end
    frozen = digits;
    gap = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      gap++;
      if (digits !== frozen) break;
    end
    n_checks++;
    if (gap != 2) begin n_fail++; $display("FAIL resume_phase: got %0d cycles expected 2", gap); end
    btn_start = 1'b0;
    repeat (DEB + 4) @(negedge clk);
  endtask

  task automatic test_clear_priority();
    logic [15:0] v;
    bit seen;
    up_down = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (m_presc == 1 && m_mode == 1) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen || running !== 1'b1) begin n_fail++; $display("FAIL clr_setup: got running=%b expected RUN", running); end
    btn_start = 1'b1;
    btn_clear = 1'b1;
    repeat (DEB + 3) @(negedge clk);
    n_checks++;
    if (running !== 1'b1 || digits === 16'h0000) begin
      n_fail++; $display("FAIL clr_before: got running=%b digits=%h expected running nonzero", running, digits);
    end
    @(negedge clk);
    n_checks += 3;
    if (running !== 1'b0) begin n_fail++; $display("FAIL clr_running: got %b expected 0", running); end
    if (digits !== 16'h0000) begin n_fail++; $display("FAIL clr_digits: got %h expected 0000", digits); end
    if (rc !== 1'b0) begin n_fail++; $display("FAIL clr_rc: got %b expected 0", rc); end
    btn_start = 1'b0;
    btn_clear = 1'b0;
    for (int k = 0; k < DEB + 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (digits !== 16'h0000 || running !== 1'b0) begin
        n_fail++; $display("FAIL clr_hold: got digits=%h running=%b expected 0000 0", digits, running);
      end
    end
    press(1'b1, 1'b0);
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL clr_restart: got %b expected 1", running); end
    wait_change("restart", 8, v);
    n_checks++;
    if (v !== 16'h0001) begin n_fail++; $display("FAIL restart_0001: got %h expected 0001", v); end
  endtask

  task automatic test_random();
    int hold_s;
    int hold_c;
    hold_s = 0;
    hold_c = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      n_checks += 5;
      if (digits !== to_bcd(m_count)) begin n_fail++; $display("FAIL rnd_digits: got %h expected %h", digits, to_bcd(m_count)); end
      if (rc !== m_rc) begin n_fail++; $display("FAIL rnd_rc: got %b expected %b", rc, m_rc); end
      if (running !== (m_mode == 1)) begin n_fail++; $display("FAIL rnd_running: got %b expected %b", running, m_mode == 1); end
      if (an !== m_an) begin n_fail++; $display("FAIL rnd_an: got %b expected %b", an, m_an); end
      if (digit_sel !== m_sel) begin n_fail++; $display("FAIL rnd_sel: got %h expected %h", digit_sel, m_sel); end
      if ($urandom_range(0, 7) == 0) up_down = 1'($urandom);
      if (hold_s == 0) begin
        btn_start = ($urandom_range(0, 5) == 0);
        hold_s = $urandom_range(1, 12);
      end else begin
        hold_s--;
      end
      if (hold_c == 0) begin
        btn_clear = ($urandom_range(0, 24) == 0);
        hold_c = $urandom_range(1, 10);
      end else begin
        hold_c--;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_debounce();
    test_count_up();
    test_count_down();
    test_pause_resume();
    test_clear_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Controller that sequences the cascaded 4-digit BCD counter datapath feeding the 4-digit seven-segment display. It divides the board clock into a count tick and gates it with a run/pause/clear state machine driven by debounced buttons. It performs BCD cascade (digit carry) and up/down counting, and time-multiplexes the four digits onto the anode/digit outputs. It replaces the free-running divider-plus-counter arrangement at board top level.

Parameters:
TICK_DIV, 50000000, clk cycles per count tick (1 s at 50 MHz); must be >= 2.
SCAN_DIV, 100000, clk cycles per display digit slot; must be >= 1.
DEB_CYCLES, 1000000, consecutive stable synchronized cycles required to accept a button level; must be >= 1.

Ports:
clk  input  1  board clock; all logic on rising edge
rst  input  1  synchronous active-high reset
btn_start  input  1  asynchronous raw button; press toggles run/pause
btn_clear  input  1  asynchronous raw button; press clears and stops
up_down  input  1  1 = count up, 0 = count down; sampled on each tick
digits  output  16  BCD count, digit3 in [15:12] down to digit0 in [3:0]
an  output  4  active-low anode enables, exactly one low
digit_sel  output  4  BCD value of the currently enabled digit
rc  output  1  one-cycle pulse on wrap (9999->0000 up, 0000->9999 down)
running  output  1  high while state is RUN

Behaviour:
- Reset (rst=1 at posedge): state IDLE; digits=0; prescaler=0; rc=0; running=0; scan index=0; scan counter=0; an=4'b1110; digit_sel=0; debouncer stable levels=0, and their counters are cleared.
- Button path: 2-FF synchronizer, then debounce. The accepted level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles. A one-cycle press pulse is issued on an accepted 0->1 transition. Latency from a raw rising edge to the pulse is DEB_CYCLES+3 cycles. Releases produce no pulse.
- State machine (IDLE, RUN, PAUSE):
  - clear_pulse in any state -> IDLE. clear_pulse zeroes digits and prescaler on the same edge.
  - start_pulse: IDLE -> RUN; RUN -> PAUSE; PAUSE -> RUN.
  - When clear_pulse and start_pulse occur in the same cycle, clear wins and start is discarded.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN. tick=1 in the cycle where prescaler==TICK_DIV-1; the prescaler then returns to 0.
  - In PAUSE the prescaler holds its value, so the phase is preserved across pause.
  - First tick after IDLE->RUN occurs TICK_DIV cycles after entering RUN.
- Count update on tick (registered; digits change on the edge after tick is asserted):
  - Up: digit0 increments. A digit at 9 becomes 0 and carries to the next digit.
  - Down: digit0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - Digits never hold values above 9.
  - Wrap (9999->0000 up or 0000->9999 down) asserts rc for exactly the same cycle the wrapped value first appears.
  - If tick and clear_pulse occur in the same cycle, clear wins: digits=0, rc=0.
  - Changing up_down between ticks is legal and takes effect on the next tick.
- running = (state==RUN), registered with the state.
- Display scan:
  - Runs in all states, independent of the state machine.
  - Scan counter counts 0..SCAN_DIV-1. On its terminal count, the scan index advances 0->1->2->3->0.
  - an = ~(4'b0001 << index); digit_sel = digits[4*index +: 4].
  - Both are registered; they reflect digits one cycle late.

Decomposition:
- Package stopwatch_pkg: state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2), BCD_MAX=4'd9, NUM_DIGITS=4.
- One sub-module, btn_debounce (synchronizer + debounce + rising-edge pulse, parameter DEB_CYCLES), instantiated for btn_start and btn_clear.
- BCD cascade and scan logic stay inline.

Test Plan:
All scenarios use TICK_DIV=4, SCAN_DIV=2, DEB_CYCLES=3.
1. Reset and scan: assert rst 2 cycles, then release, hold buttons low -> digits=0, running=0, rc=0; an sequence 1110,1101,1011,0111, repeating, each held 2 cycles; digit_sel=0.
2. Debounce: btn_start glitch high for 2 cycles -> no state change. Hold btn_start high for 10 cycles -> running=1 from DEB_CYCLES+4 cycles after the edge; exactly one start pulse.
3. Count up with carry: RUN with up_down=1, preload by counting to 0009 -> next tick gives 0010. From 9999, the next tick gives 0000 with rc high for exactly 1 cycle.
4. Count down with borrow: up_down=0 from 0010 -> 0009. From 0000 -> 9999 with rc=1 for 1 cycle.
5. Pause/resume: start, wait 6 cycles (1 tick plus prescaler=2), then press start -> digits frozen for 20 cycles. Press start again -> the next tick arrives 2 cycles after re-entering RUN.
6. Clear priority: drive the clear and start pulses in the same cycle while in RUN, with a tick also due -> state IDLE, digits=0, rc=0, running=0. A later start -> RUN from 0000.
